// File: rtl/shift_rx_pkg.sv
// Shared definitions for the serial word receiver: default geometry and FSM encoding.
package shift_rx_pkg;

   localparam int DEF_WIDTH = 3;
   localparam int DEF_DEPTH = 2;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } rx_state_t;

endpackage

// File: rtl/shift_rx_fifo.sv
// Small circular word buffer with occupancy counter; q reads 0 while empty.
module shift_rx_fifo
   import shift_rx_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A full buffer still accepts a word when the head leaves on the same edge.
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Word storage; contents are meaningless while count says empty, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/shift_receiver.sv
// Serial-to-parallel receiver: MSB-first bits with strobe and start-of-word resync,
// completed words queued in a small buffer with a sticky drop flag.
module shift_receiver
   import shift_rx_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             di,
   input  logic             di_en,
   input  logic             sof,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   input  logic             q_ready,
   output logic             busy,
   output logic             overrun
);

   localparam int CW = $clog2(WIDTH + 1);

   rx_state_t        state_q;
   rx_state_t        state_d;
   logic [WIDTH-1:0] sreg_q;
   logic [WIDTH-1:0] sreg_d;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic [WIDTH-1:0] base;
   logic [CW-1:0]    cnt_inc;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;
   logic             overrun_q;

   // sof throws away whatever partial word is held and restarts the count at this bit.
   assign base    = sof ? '0 : sreg_q;
   assign cnt_inc = sof ? CW'(1) : cnt_q + CW'(1);
   assign pop     = q_ready && q_valid;
   assign q_valid = !empty;
   assign busy    = (state_q == RECV);
   assign overrun = overrun_q;

   // FSM state, shift register and bit counter.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: shift on strobe, push and return to IDLE on the last bit.
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      push    = 1'b0;
      if (di_en) begin
         sreg_d = (base << 1) | WIDTH'(di);
         if (cnt_inc == CW'(WIDTH)) begin
            push    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
         end else begin
            cnt_d   = cnt_inc;
            state_d = RECV;
         end
      end
   end

   // Sticky drop flag: a word completed into a full buffer with no pop is lost.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         overrun_q <= 1'b0;
      end else if (push && full && !pop) begin
         overrun_q <= 1'b1;
      end
   end

   shift_rx_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .clr   (clr),
      .push  (push),
      .pop   (pop),
      .din   (sreg_d),
      .dout  (q),
      .full  (full),
      .empty (empty)
   );

endmodule

// File: tb/tb_shift_receiver.sv
// Directed bench for shift_receiver: stimulus queues expected words, a monitor
// compares every word the DUT hands over, and inline checks cover status flags.
module tb_shift_receiver;

   logic       clk;
   logic       clr;
   logic       di;
   logic       di_en;
   logic       sof;
   logic [2:0] q;
   logic       q_valid;
   logic       q_ready;
   logic       busy;
   logic       overrun;

   int         checks = 0;
   int         errors = 0;
   logic [2:0] exp_q [$];

   shift_receiver dut (
      .clk     (clk),
      .clr     (clr),
      .di      (di),
      .di_en   (di_en),
      .sof     (sof),
      .q       (q),
      .q_valid (q_valid),
      .q_ready (q_ready),
      .busy    (busy),
      .overrun (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic send_bit(input logic b, input logic s);
      di    = b;
      sof   = s;
      di_en = 1'b1;
      @(posedge clk);
      #1;
      di_en = 1'b0;
      sof   = 1'b0;
      di    = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      q_ready = 1'b1;
      idle(4);
      q_ready = 1'b0;
   endtask

   // Monitor: a handshake seen on the falling edge completes on the next rising edge.
   always @(negedge clk) begin
      if (!clr && q_valid && q_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %b expected none at %0t", q, $time);
         end else begin
            check("word_out", 32'(q), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clr = 1'b1; di = 1'b0; di_en = 1'b0; sof = 1'b0; q_ready = 1'b0;
      idle(2);
      check("rst_q", 32'(q), 0);
      check("rst_q_valid", 32'(q_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_overrun", 32'(overrun), 0);
      clr = 1'b0;
      idle(1);

      // basic receive 1,0,1
      send_bit(1'b1, 1'b1);
      check("basic_busy_mid", 32'(busy), 1);
      send_bit(1'b0, 1'b0);
      check("basic_no_valid_early", 32'(q_valid), 0);
      send_bit(1'b1, 1'b0);
      exp_q.push_back(3'b101);
      check("basic_q", 32'(q), 32'(3'b101));
      check("basic_valid", 32'(q_valid), 1);
      check("basic_busy_end", 32'(busy), 0);
      drain();
      check("basic_drained", 32'(q_valid), 0);
      check("basic_q_zero", 32'(q), 0);

      // gapped strobe 0,1,1
      send_bit(1'b0, 1'b1);
      idle(4);
      check("gap_busy1", 32'(busy), 1);
      send_bit(1'b1, 1'b0);
      idle(4);
      check("gap_busy2", 32'(busy), 1);
      check("gap_no_valid", 32'(q_valid), 0);
      send_bit(1'b1, 1'b0);
      exp_q.push_back(3'b011);
      check("gap_q", 32'(q), 32'(3'b011));
      drain();

      // resync: 1,1 then sof 0,0,1
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b1);
      check("resync_no_word", 32'(q_valid), 0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      exp_q.push_back(3'b001);
      check("resync_q", 32'(q), 32'(3'b001));
      drain();
      check("resync_single", 32'(q_valid), 0);

      // overrun: three words without pops
      send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
      check("ovr_not_yet", 32'(overrun), 0);
      send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
      exp_q.push_back(3'b111);
      exp_q.push_back(3'b010);
      check("ovr_flag", 32'(overrun), 1);
      check("ovr_head", 32'(q), 32'(3'b111));
      check("ovr_valid", 32'(q_valid), 1);
      drain();
      check("ovr_empty", 32'(q_valid), 0);
      check("ovr_sticky", 32'(overrun), 1);

      // clear sticky flag before the full-with-pop case
      clr = 1'b1;
      idle(1);
      check("clr_overrun", 32'(overrun), 0);
      clr = 1'b0;
      idle(1);

      // full buffer with pop on the edge of the third word
      send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
      exp_q.push_back(3'b001);
      exp_q.push_back(3'b010);
      exp_q.push_back(3'b011);
      send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0);
      q_ready = 1'b1;
      send_bit(1'b1, 1'b0);
      q_ready = 1'b0;
      check("fullpop_no_ovr", 32'(overrun), 0);
      check("fullpop_head", 32'(q), 32'(3'b010));
      drain();
      check("fullpop_empty", 32'(q_valid), 0);

      // mid-word reset: 1,0 then clr, then 1,1,0
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b0);
      clr = 1'b1;
      #1;
      check("midclr_busy", 32'(busy), 0);
      check("midclr_q", 32'(q), 0);
      check("midclr_valid", 32'(q_valid), 0);
      check("midclr_ovr", 32'(overrun), 0);
      idle(2);
      clr = 1'b0;
      idle(1);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      exp_q.push_back(3'b110);
      check("midclr_word", 32'(q), 32'(3'b110));
      check("midclr_no_ovr", 32'(overrun), 0);
      drain();

      check("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
